// File: rtl/zero_insert_pad_layer.sv
// Streaming zero-insertion and border padder for transposed-convolution inputs.
// Output register is the only storage; counters track the next beat to load.
module zero_insert_pad_layer #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 1,
    parameter int IMG_WIDTH  = 7,
    parameter int IMG_HEIGHT = 7,
    parameter int STRIDE     = 2,
    parameter int PAD_TOP    = 1,
    parameter int PAD_BOTTOM = 2,
    parameter int PAD_LEFT   = 1,
    parameter int PAD_RIGHT  = 2,
    parameter logic signed [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         ready_in,
    input  logic                         ready_out,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         sof_out,
    output logic                         eof_out
);

    localparam int CW  = (IMG_WIDTH - 1) * STRIDE + 1;
    localparam int CHT = (IMG_HEIGHT - 1) * STRIDE + 1;
    localparam int OW  = PAD_LEFT + CW + PAD_RIGHT;
    localparam int OH  = PAD_TOP + CHT + PAD_BOTTOM;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OXW = (OW > 1) ? $clog2(OW) : 1;
    localparam int OYW = (OH > 1) ? $clog2(OH) : 1;
    localparam int PW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [CHW-1:0] ch_q, ch_d;
    logic [OXW-1:0] ox_q, ox_d;
    logic [OYW-1:0] oy_q, oy_d;
    logic [PW-1:0]  px_q, px_d;
    logic [PW-1:0]  py_q, py_d;

    logic                         valid_q;
    logic                         sof_q;
    logic                         eof_q;
    logic signed [DATA_WIDTH-1:0] data_q;

    logic ch_last, ox_last, oy_last;
    logic in_x, in_y, is_real;
    logic load, adv;
    logic frame_first, frame_last;

    always_comb begin
        ch_last = int'(ch_q) == CHANNELS - 1;
        ox_last = int'(ox_q) == OW - 1;
        oy_last = int'(oy_q) == OH - 1;
        in_x    = int'(ox_q) >= PAD_LEFT && int'(ox_q) < PAD_LEFT + CW;
        in_y    = int'(oy_q) >= PAD_TOP && int'(oy_q) < PAD_TOP + CHT;
        // phase counters are zero exactly on stride-aligned columns/rows
        is_real = in_x && in_y && px_q == '0 && py_q == '0;
        load    = !valid_q || ready_out;
        adv     = load && (!is_real || valid_in);
        frame_first = ch_q == '0 && ox_q == '0 && oy_q == '0;
        frame_last  = ch_last && ox_last && oy_last;
    end

    assign ready_in = load && is_real;

    always_comb begin
        ch_d = ch_q;
        ox_d = ox_q;
        oy_d = oy_q;
        px_d = px_q;
        py_d = py_q;
        if (adv) begin
            ch_d = ch_last ? '0 : ch_q + 1'b1;
            if (ch_last) begin
                ox_d = ox_last ? '0 : ox_q + 1'b1;
                if (ox_last || int'(ox_q) < PAD_LEFT) begin
                    px_d = '0;
                end else begin
                    px_d = (int'(px_q) == STRIDE - 1) ? '0 : px_q + 1'b1;
                end
                if (ox_last) begin
                    oy_d = oy_last ? '0 : oy_q + 1'b1;
                    if (oy_last || int'(oy_q) < PAD_TOP) begin
                        py_d = '0;
                    end else begin
                        py_d = (int'(py_q) == STRIDE - 1) ? '0 : py_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            ch_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            if (load) begin
                valid_q <= adv;
                if (adv) begin
                    data_q <= is_real ? data_in : PAD_VALUE;
                    sof_q  <= frame_first;
                    eof_q  <= frame_last;
                end
            end
            ch_q <= ch_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sof_out   = sof_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_zero_insert_pad_layer.sv
// Bench for zero_insert_pad_layer: three configurations, arithmetic frame model.
// One negedge process performs every comparison, including literal pins.
module tb_zero_insert_pad_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rn[3], vi[3], ro[3], ri[3], vo[3], sf[3], ef[3];
    logic signed [15:0] di[3], dq[3];

    zero_insert_pad_layer #(
        .DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(2), .IMG_HEIGHT(2),
        .STRIDE(2), .PAD_TOP(1), .PAD_BOTTOM(1), .PAD_LEFT(1),
        .PAD_RIGHT(1), .PAD_VALUE(16'sd0)
    ) u_a (
        .clk(clk), .rst_n(rn[0]), .valid_in(vi[0]), .data_in(di[0]),
        .ready_in(ri[0]), .ready_out(ro[0]), .valid_out(vo[0]),
        .data_out(dq[0]), .sof_out(sf[0]), .eof_out(ef[0])
    );

    zero_insert_pad_layer #(
        .DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(14), .IMG_HEIGHT(14),
        .STRIDE(1), .PAD_TOP(1), .PAD_BOTTOM(2), .PAD_LEFT(1),
        .PAD_RIGHT(2), .PAD_VALUE(16'sd0)
    ) u_b (
        .clk(clk), .rst_n(rn[1]), .valid_in(vi[1]), .data_in(di[1]),
        .ready_in(ri[1]), .ready_out(ro[1]), .valid_out(vo[1]),
        .data_out(dq[1]), .sof_out(sf[1]), .eof_out(ef[1])
    );

    zero_insert_pad_layer #(
        .DATA_WIDTH(16), .CHANNELS(3), .IMG_WIDTH(1), .IMG_HEIGHT(2),
        .STRIDE(2), .PAD_TOP(0), .PAD_BOTTOM(0), .PAD_LEFT(0),
        .PAD_RIGHT(0), .PAD_VALUE(-16'sd1)
    ) u_c (
        .clk(clk), .rst_n(rn[2]), .valid_in(vi[2]), .data_in(di[2]),
        .ready_in(ri[2]), .ready_out(ro[2]), .valid_out(vo[2]),
        .data_out(dq[2]), .sof_out(sf[2]), .eof_out(ef[2])
    );

    int cW[3]  = '{2, 14, 1};
    int cH[3]  = '{2, 14, 2};
    int cS[3]  = '{2, 1, 2};
    int cPT[3] = '{1, 1, 0};
    int cPB[3] = '{1, 2, 0};
    int cPL[3] = '{1, 1, 0};
    int cPR[3] = '{1, 2, 0};
    int cC[3]  = '{1, 1, 3};
    int cPV[3] = '{0, 0, -1};

    int litA[25] = '{0,0,0,0,0, 0,1,0,2,0, 0,0,0,0,0, 0,3,0,4,0, 0,0,0,0,0};
    int litR[8]  = '{6, 8, 16, 18, 31, 33, 41, 43};
    int litC[9]  = '{10, 11, 12, -1, -1, -1, 20, 21, 22};

    int n_chk = 0;
    int n_fail = 0;

    int kk[3], base[3], acc[3], nin[3];
    bit clr[3];
    int seq[3][400];
    logic signed [15:0] bdat[3][512];
    logic bsof[3][512], beof[3][512];
    int bcyc[3][512];
    logic pst[3], psf[3], pef[3];
    logic signed [15:0] pdat[3];
    int riq[$];
    int lit_req = 0;
    int lit_done = 0;

    task automatic chk(input string nm, input int i,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, want %0d", nm, i, act, exp);
        end
    endtask

    function automatic int flen(input int d);
        int cw, chh;
        cw  = (cW[d] - 1) * cS[d] + 1;
        chh = (cH[d] - 1) * cS[d] + 1;
        return (cPL[d] + cw + cPR[d]) * (cPT[d] + chh + cPB[d]) * cC[d];
    endfunction

    // Map a beat index within a frame to its pixel and source sample
    function automatic void model(input int d, input int k,
                                  output bit rl, output int idx);
        int cw, chh, ow, c, p, ox, oy;
        bit rx, ry;
        cw  = (cW[d] - 1) * cS[d] + 1;
        chh = (cH[d] - 1) * cS[d] + 1;
        ow  = cPL[d] + cw + cPR[d];
        c   = k % cC[d];
        p   = k / cC[d];
        ox  = p % ow;
        oy  = p / ow;
        rx  = ox >= cPL[d] && ox < cPL[d] + cw && (ox - cPL[d]) % cS[d] == 0;
        ry  = oy >= cPT[d] && oy < cPT[d] + chh && (oy - cPT[d]) % cS[d] == 0;
        rl  = rx && ry;
        idx = 0;
        if (rl) idx = (((oy - cPT[d]) / cS[d]) * cW[d]
                       + (ox - cPL[d]) / cS[d]) * cC[d] + c;
    endfunction

    task automatic mon(input int d);
        bit rl;
        int idx, pos, e, f, k, g, fl;
        fl = flen(d);
        if (!rn[d]) begin
            chk("reset_out", d, {vo[d], sf[d], ef[d], dq[d]}, 0);
            if (clr[d]) acc[d] = 0;
            if (clr[d] && d == 0) riq.delete();
            kk[d] = 0;
            base[d] = acc[d];
            pst[d] = 1'b0;
            return;
        end
        pos = kk[d] + (vo[d] ? 1 : 0);
        model(d, pos % fl, rl, idx);
        chk("ready_in", d, ri[d], rl && (!vo[d] || ro[d]));
        if (pst[d]) chk("stall_hold", d, {vo[d], sf[d], ef[d], dq[d]},
                        {1'b1, psf[d], pef[d], pdat[d]});
        if (vo[d] && ro[d]) begin
            f = kk[d] / fl;
            k = kk[d] % fl;
            model(d, k, rl, idx);
            g = base[d] + f * cW[d] * cH[d] * cC[d] + idx;
            e = (rl && g < 400) ? seq[d][g] : cPV[d];
            chk("data", d, dq[d], e);
            chk("sof", d, sf[d], k == 0);
            chk("eof", d, ef[d], k == fl - 1);
            if (kk[d] < 512) begin
                bdat[d][kk[d]] = dq[d];
                bsof[d][kk[d]] = sf[d];
                beof[d][kk[d]] = ef[d];
                bcyc[d][kk[d]] = cyc;
            end
            kk[d]++;
        end
        if (vi[d] && ri[d]) begin
            if (d == 0) riq.push_back(pos);
            acc[d]++;
        end
        pst[d]  = vo[d] && !ro[d];
        pdat[d] = dq[d];
        psf[d]  = sf[d];
        pef[d]  = ef[d];
    endtask

    task automatic lit(input int p);
        if (p == 1 || p == 2) begin
            chk("A_beats", p, kk[0] >= 50, 1);
            for (int i = 0; i < 25; i++) begin
                chk("A_frame1", i, bdat[0][i], litA[i]);
                chk("A_frame2", i, bdat[0][25 + i],
                    litA[i] == 0 ? 0 : litA[i] + 4);
            end
            chk("A_sof2", p, bsof[0][25], 1);
            chk("A_eof1", p, beof[0][24], 1);
            chk("A_eof2", p, beof[0][49], 1);
        end
        if (p == 1) begin
            for (int i = 0; i < 49; i++)
                chk("A_gap", i, bcyc[0][i + 1] - bcyc[0][i], 1);
            chk("A_rdy_n", 0, riq.size(), 8);
            for (int i = 0; i < 8; i++)
                chk("A_rdy_pos", i, i < riq.size() ? riq[i] : -1, litR[i]);
        end
        if (p == 2) chk("A_bp_acc", 0, acc[0], 8);
        if (p == 3) begin
            chk("R_beats", 0, kk[0] >= 25, 1);
            chk("R_sof", 0, bsof[0][0], 1);
            chk("R_first", 0, bdat[0][0], 0);
            chk("R_pix11", 0, bdat[0][6], 3);
            chk("R_pix13", 0, bdat[0][8], 4);
            chk("R_pix31", 0, bdat[0][16], 5);
            chk("R_pix33", 0, bdat[0][18], 6);
            chk("R_eof", 0, beof[0][24], 1);
        end
        if (p == 4) begin
            chk("B_beats", 0, kk[1] >= 289, 1);
            chk("B_sof", 0, bsof[1][0], 1);
            for (int x = 0; x < 17; x++) chk("B_row0", x, bdat[1][x], 0);
            chk("B_row1_l", 0, bdat[1][17], 0);
            for (int j = 0; j < 14; j++)
                chk("B_row1", j, bdat[1][18 + j], j + 1);
            chk("B_row1_r0", 0, bdat[1][32], 0);
            chk("B_row1_r1", 0, bdat[1][33], 0);
            chk("B_row14", 0, bdat[1][239], 183);
            for (int x = 255; x < 289; x++) chk("B_bottom", x, bdat[1][x], 0);
            chk("B_eof", 0, beof[1][288], 1);
        end
        if (p == 5) begin
            chk("C_beats", 0, kk[2] >= 9, 1);
            for (int i = 0; i < 9; i++) chk("C_out", i, bdat[2][i], litC[i]);
            chk("C_eof", 0, beof[2][8], 1);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        mon(2);
        if (lit_done != lit_req) begin
            lit(lit_req);
            lit_done = lit_req;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input int n);
        clr[d] = 1'b1;
        rn[d] = 1'b0;
        vi[d] = 1'b0;
        ro[d] = 1'b0;
        di[d] = '0;
        nin[d] = n;
        repeat (2) tick();
        rn[d] = 1'b1;
        clr[d] = 1'b0;
    endtask

    task automatic run(input int d, input int nb, input int vp,
                       input int rp, input int rst_at, input int maxc);
        int c0;
        bit did;
        c0 = cyc;
        did = (rst_at < 0);
        while (!(did && kk[d] >= nb) && (cyc - c0 <= maxc)) begin
            if (!did && kk[d] == rst_at) begin
                rn[d] = 1'b0;
                vi[d] = 1'b0;
                repeat (2) tick();
                rn[d] = 1'b1;
                did = 1'b1;
            end
            vi[d] = (acc[d] < nin[d]) && ($urandom_range(99) < vp);
            di[d] = 16'(seq[d][acc[d]]);
            ro[d] = $urandom_range(99) < rp;
            tick();
        end
        vi[d] = 1'b0;
        ro[d] = 1'b0;
    endtask

    task automatic pin(input int p);
        lit_req = p;
        for (int i = 0; i < 10 && lit_done != lit_req; i++) tick();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rn[d] = 1'b0;
            vi[d] = 1'b0;
            ro[d] = 1'b0;
            di[d] = '0;
            clr[d] = 1'b1;
        end
        repeat (2) tick();

        for (int i = 0; i < 8; i++) seq[0][i] = i + 1;
        start(0, 8);
        run(0, 50, 100, 100, -1, 200);
        pin(1);

        start(0, 8);
        run(0, 50, 60, 50, -1, 3000);
        pin(2);

        start(0, 8);
        run(0, 25, 100, 100, 11, 300);
        pin(3);

        for (int i = 0; i < 196; i++) seq[1][i] = i + 1;
        start(1, 196);
        run(1, 289, 100, 100, -1, 800);
        pin(4);

        for (int i = 0; i < 6; i++) seq[2][i] = litC[i < 3 ? i : i + 3];
        start(2, 6);
        run(2, 9, 100, 100, -1, 100);
        pin(5);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
